// File: rtl/ram_pkg.sv
// Shared definitions for the two-port RAM arbiter.
package ram_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  // Requester identity: port 0 (e.g. fetch) or port 1 (e.g. load/store).
  typedef logic port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  // Outstanding-read marker carried from the grant cycle to the rvalid cycle.
  typedef struct packed {
    logic      valid;
    port_id_t  port;
  } rd_tag_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle: two request/grant channels plus their read returns.
interface ram_arbiter_if
  import ram_pkg::*;
#(
  parameter int dataWidth = DATA_W,
  parameter int multWidth = ADDR_W
);

  logic                 req0, req1;
  logic                 we0, we1;
  logic [multWidth-1:0] addr0, addr1;
  logic [dataWidth-1:0] wdata0, wdata1;
  logic                 gnt0, gnt1;
  logic                 rvalid0, rvalid1;
  logic [dataWidth-1:0] rdata0, rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin grant; a tie goes to the port that was not granted last.
module rr_arb2
  import ram_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  port_id_t last_gnt;

  // Combinational grant; held off while reset is asserted.
  always_comb begin
    gnt0 = rst_n & req0 & (~req1 | (last_gnt == PORT1));
    gnt1 = rst_n & req1 & (~req0 | (last_gnt == PORT0));
  end

  // Remember the winner; reset value lets port 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= PORT1;
    end else if (gnt0) begin
      last_gnt <= PORT0;
    end else if (gnt1) begin
      last_gnt <= PORT1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous single-read/single-write RAM between two requesters.
// One access per cycle; reads return one cycle after the grant.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int dataWidth = DATA_W,
  parameter int multWidth = ADDR_W
)(
  input  logic                 clk,
  input  logic                 rst_n,
  ram_arbiter_if.slave         bus,
  output logic [multWidth-1:0] ram_readAddress,
  output logic [multWidth-1:0] ram_writeAddress,
  output logic                 ram_write,
  output logic [dataWidth-1:0] ram_in,
  input  logic [dataWidth-1:0] ram_out
);

  logic                 gnt0, gnt1;
  port_id_t             sel;
  logic                 sel_we;
  logic [multWidth-1:0] sel_addr;
  logic [dataWidth-1:0] sel_wdata;
  logic                 wr_go, rd_go;

  logic [multWidth-1:0] raddr_q, waddr_q;
  logic [dataWidth-1:0] win_q;
  rd_tag_t              tag_q;
  logic [dataWidth-1:0] rdata0_q, rdata1_q;
  logic                 rvalid0, rvalid1;

  rr_arb2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (bus.req0),
    .req1 (bus.req1),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;

  // Mux the granted port's command onto a single internal access.
  always_comb begin
    sel       = gnt1 ? PORT1 : PORT0;
    sel_we    = gnt1 ? bus.we1    : bus.we0;
    sel_addr  = gnt1 ? bus.addr1  : bus.addr0;
    sel_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
    wr_go     = (gnt0 | gnt1) & sel_we;
    rd_go     = (gnt0 | gnt1) & ~sel_we;
  end

  // RAM address/data hold their last used values while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raddr_q <= '0;
      waddr_q <= '0;
      win_q   <= '0;
    end else begin
      if (wr_go) begin
        waddr_q <= sel_addr;
        win_q   <= sel_wdata;
      end
      if (rd_go) begin
        raddr_q <= sel_addr;
      end
    end
  end

  // Drive RAM controls straight from the grant so the access lands this cycle.
  always_comb begin
    ram_write        = wr_go;
    ram_writeAddress = wr_go ? sel_addr  : waddr_q;
    ram_in           = wr_go ? sel_wdata : win_q;
    ram_readAddress  = rd_go ? sel_addr  : raddr_q;
  end

  // Tag each granted read so the returning data is steered to its owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else begin
      tag_q.valid <= rd_go;
      if (rd_go) begin
        tag_q.port <= sel;
      end
    end
  end

  assign rvalid0 = tag_q.valid & (tag_q.port == PORT0);
  assign rvalid1 = tag_q.valid & (tag_q.port == PORT1);

  // Capture returned data so each port's rdata holds after its rvalid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= ram_out;
      if (rvalid1) rdata1_q <= ram_out;
    end
  end

  // Bypass RAM output during rvalid so data is valid with the strobe.
  always_comb begin
    bus.rvalid0 = rvalid0;
    bus.rvalid1 = rvalid1;
    bus.rdata0  = rvalid0 ? ram_out : rdata0_q;
    bus.rdata1  = rvalid1 ? ram_out : rdata1_q;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and scoreboard.
module tb_ram_arbiter;
  import ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.dataWidth(DATA_W), .multWidth(ADDR_W)) bus ();

  logic [ADDR_W-1:0] ram_readAddress, ram_writeAddress;
  logic              ram_write;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out = '0;
  logic [DATA_W-1:0] mem [16];

  ram_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .ram_readAddress (ram_readAddress),
    .ram_writeAddress(ram_writeAddress),
    .ram_write       (ram_write),
    .ram_in          (ram_in),
    .ram_out         (ram_out)
  );

  // Synchronous RAM: registered read, old data on same-cycle same-address write.
  always @(posedge clk) begin
    if (ram_write) mem[ram_writeAddress] <= ram_in;
    ram_out <= mem[ram_readAddress];
  end

  typedef struct {
    int           port;
    logic [31:0]  data;
    time          t_grant;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [16];
  int          last_m;
  int          checks = 0;
  int          errors = 0;
  int          rv0_run, rv0_max_run;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of requests, predict the grant and RAM controls, update model.
  task automatic step(input logic r0, input logic w0, input logic [3:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [3:0] a1, input logic [31:0] d1,
                      output logic e0, output logic e1);
    int p;
    logic w;
    logic [3:0] a;
    logic [31:0] d;
    bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    #1;
    e0 = r0 && (!r1 || last_m == 1);
    e1 = r1 && !e0;
    check("gnt0", bus.gnt0, e0);
    check("gnt1", bus.gnt1, e1);
    p = e1 ? 1 : 0;
    w = e1 ? w1 : w0;
    a = e1 ? a1 : a0;
    d = e1 ? d1 : d0;
    check("ram_write", ram_write, (e0 || e1) && w);
    if (e0 || e1) begin
      if (w) begin
        check("ram_waddr", ram_writeAddress, a);
        check("ram_in", ram_in, d);
        ref_mem[a] = d;
      end else begin
        check("ram_raddr", ram_readAddress, a);
        exp_q.push_back('{p, ref_mem[a], $time});
      end
      last_m = p;
    end
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    last_m = 1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic mon_port(input int p, input logic [31:0] rd);
    exp_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_rvalid%0d", p), 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("rvalid_port", p, e.port);
      check($sformatf("rdata%0d", p), rd, e.data);
      check("read_latency", $time - e.t_grant, 13);
    end
  endtask

  initial begin
    logic g0, g1;
    logic        pr [2];
    logic        pw [2];
    logic [3:0]  pa [2];
    logic [31:0] pd [2];

    idle_inputs();
    last_m = 1;
    rv0_run = 0;
    rv0_max_run = 0;

    // Scoreboard monitor: pops an expectation on every rvalid.
    fork
      forever begin
        @(negedge clk);
        if (bus.rvalid0 && bus.rvalid1) check("rvalid_both", 1, 0);
        if (bus.rvalid0) mon_port(0, bus.rdata0);
        if (bus.rvalid1) mon_port(1, bus.rdata1);
        if (bus.rvalid0) rv0_run++;
        else rv0_run = 0;
        if (rv0_run > rv0_max_run) rv0_max_run = rv0_run;
      end
    join_none

    // Reset state and idle.
    #12;
    check("rst_gnt0", bus.gnt0, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_raddr", ram_readAddress, 0);
    check("rst_waddr", ram_writeAddress, 0);
    check("rst_ram_in", ram_in, 0);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, g0, g1);
      tick();
    end
    check("idle_rvalid0", bus.rvalid0, 0);
    check("idle_rvalid1", bus.rvalid1, 0);
    check("idle_rdata0", bus.rdata0, 0);
    check("idle_rdata1", bus.rdata1, 0);

    // Preload the whole RAM through port 1.
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 0, 1, 1, 4'(i), $urandom, g0, g1);
      tick();
    end

    // Port 0 write then read-back of the same address.
    step(1, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, g0, g1);
    tick();
    step(1, 0, 4'd3, 0, 0, 0, 0, 0, g0, g1);
    tick();
    idle_inputs();
    tick();
    tick();
    check("rdata0_hold", bus.rdata0, 32'hDEADBEEF);

    // Continuous contention from a fresh reset: 0,1,0,1,0,1.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 4'd1, 0, 1, 0, 4'd2, 0, g0, g1);
      check("alternate", g1, (i % 2));
      tick();
    end
    idle_inputs();
    tick();
    tick();

    // Port 1 write wins (last grant was port 0), port 0 reads the new value.
    step(1, 0, 4'd0, 0, 0, 0, 0, 0, g0, g1);
    tick();
    step(1, 0, 4'd5, 0, 1, 1, 4'd5, 32'h12345678, g0, g1);
    tick();
    step(1, 0, 4'd5, 0, 0, 0, 0, 0, g0, g1);
    tick();
    idle_inputs();
    tick();
    tick();
    check("raw_rdata0", bus.rdata0, 32'h12345678);

    // Reset while a read is outstanding: no rvalid afterwards, port 0 wins next tie.
    step(1, 0, 4'd7, 0, 0, 0, 0, 0, g0, g1);
    #1;
    apply_reset();
    tick();
    check("post_rst_rvalid0", bus.rvalid0, 0);
    step(1, 0, 4'd8, 0, 1, 0, 4'd9, 0, g0, g1);
    tick();
    idle_inputs();
    tick();
    tick();

    // 16 back-to-back reads from port 0.
    rv0_max_run = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 4'(i), 0, 0, 0, 0, 0, g0, g1);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    check("burst_run", rv0_max_run, 16);

    // Randomized traffic; requests are held until granted, occasionally withdrawn.
    for (int p = 0; p < 2; p++) pr[p] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pr[p] && $urandom_range(0, 1) == 1) begin
          pr[p] = 1;
          pw[p] = $urandom_range(0, 2) == 0;
          pa[p] = 4'($urandom_range(0, 15));
          pd[p] = $urandom;
        end else if (pr[p] && $urandom_range(0, 7) == 0) begin
          pr[p] = 0;
        end
      end
      step(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1], g0, g1);
      if (g0) pr[0] = 0;
      if (g1) pr[1] = 0;
      tick();
    end
    idle_inputs();
    tick();
    tick();
    tick();
    check("drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
